sequence_pattern_generator: RTL
===============================

Name: sequence_pattern_generator

Overview:
Transmit-side counterpart of the team's serial sequence detectors. On a start pulse, serializes a fixed bit pattern MSB-first onto a single-bit stream `dout`. The pattern is sent a programmable number of times, with a programmable idle gap between repetitions. Drives detector inputs in system test and loopback paths.

Parameters:
PAT_W, 3, pattern width in bits (legal range 2 to 16).
PATTERN, 3'b111, bit pattern to transmit; bit PAT_W-1 is sent first.
CNT_W, 8, width of the repetition count.
GAP_W, 4, width of the inter-repetition gap length.

Ports:
clk  input  1  single clock; all logic on posedge.
rst  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
repeat_cnt  input  CNT_W  number of pattern repetitions; 0 is treated as 1; latched at start.
gap_len  input  GAP_W  idle cycles between repetitions; latched at start.
abort  input  1  synchronous cancel of the current burst.
dout  output  1  serial data, registered.
dvalid  output  1  high while dout carries a pattern (or parity) bit.
busy  output  1  high from the cycle after start is accepted until the return to IDLE.
done  output  1  one-cycle pulse after the final bit of a burst completes normally.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dout=0, dvalid=0, busy=0, done=0; all counters and latches cleared.
- All outputs are registered. Latency: start sampled high at edge N puts the first bit on dout after edge N+1.
- States and transitions:
  - IDLE: start=1 latches repeat_cnt (0 becomes 1) and gap_len, loads the shift register with PATTERN, then goes to SEND. start=0 stays in IDLE.
  - SEND: drives dout=current MSB with dvalid=1 for PAT_W consecutive cycles. After the last bit:
    - if repetitions remain and gap_len>0, go to GAP;
    - if repetitions remain and gap_len=0, reload PATTERN and stay in SEND, giving back-to-back frames with no bubble;
    - if no repetitions remain, go to IDLE and assert done for one cycle.
  - GAP: dout=0, dvalid=0 for exactly gap_len cycles, then reload PATTERN and go to SEND.
- Output timing: busy stays high through SEND and GAP. On the done cycle, busy=0 and dvalid=0.
- start while busy: ignored, with no effect on latched values.
- abort=1 in SEND or GAP: next cycle is IDLE with dout=0, dvalid=0, busy=0, and done is not asserted. abort in IDLE: no effect. abort and start together in IDLE: abort wins, start is dropped.
- Repetition counter: decrements at the end of each frame. Counts up to 2^CNT_W-1 with no wrap; a 255 burst at CNT_W=8 sends exactly 255 frames.
- Reset asserted mid-burst: immediate return to reset values; no done.

Optional Feature:
- Macro SEQGEN_PARITY_EN, defined: each frame is followed by one odd-parity bit, the XOR of PATTERN inverted. The parity bit is sent with dvalid=1, so a frame lasts PAT_W+1 cycles. The gap, done and abort rules apply after the parity bit.
- Macro not defined: frames are exactly PAT_W bits and no parity logic exists.

Decomposition:
- Package seqgen_pkg holds:
  - state encoding (IDLE, SEND, GAP) as a 2-bit typedef;
  - default PAT_W, PATTERN, CNT_W and GAP_W constants;
  - the frame-length constant, which depends on SEQGEN_PARITY_EN.
- One natural sub-module: seqgen_down_counter, a parameterized-width loadable down-counter with a zero flag. It is instantiated three times: bit index, gap, and repetition.

Test Plan:
1. Reset, then start=1 with repeat_cnt=1 and gap_len=0 -> dout=1,1,1 with dvalid=1 over 3 cycles starting 1 cycle after start; done pulses on the next cycle; busy returns to 0.
2. repeat_cnt=3, gap_len=2 -> sequence 111,00,111,00,111 on dout; dvalid low only in the gaps; exactly one done pulse; 13 busy cycles total.
3. repeat_cnt=2, gap_len=0 -> six consecutive dvalid=1 cycles with no bubble; done once.
4. PATTERN=4'b1011, repeat_cnt=0 -> dout=1,0,1,1 (treated as 1 repetition); a start pulsed mid-frame is ignored.
5. abort during the 2nd bit of repetition 2 of 3 -> dout=0, dvalid=0, busy=0 next cycle; done never asserts; a later start runs a fresh burst correctly.
6. rst driven low asynchronously mid-GAP (between clock edges) -> all outputs 0 immediately. With SEQGEN_PARITY_EN and PATTERN=3'b111 -> frame is 1,1,1,0.

Source files
------------

// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared state encoding, default parameters and frame length for the pattern generator
//   SEQGEN_PARITY_EN adds one odd-parity bit to every frame.
package seqgen_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
  localparam int DEF_PAT_W = 3;
  localparam logic [2:0] DEF_PATTERN = 3'b111;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_GAP_W = 4;
`ifdef SEQGEN_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  function automatic int frame_len(input int pat_w);
    return pat_w + PAR_BITS;
  endfunction
endpackage

// File: rtl/seqgen_down_counter.sv
// seqgen_down_counter: loadable down-counter that stops at zero and flags it
//   clk, rst (async active-low), load/val (load wins), dec, zero (count is 0)
module seqgen_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/sequence_pattern_generator.sv
// sequence_pattern_generator: serializes PATTERN MSB-first, repeat_cnt times with gap_len idle cycles between frames
//   in:  clk, rst (async active-low), start, repeat_cnt, gap_len, abort
//   out: dout, dvalid, busy, done (all registered, one cycle behind the FSM state)
//   SEQGEN_PARITY_EN: each frame ends with an odd-parity bit (~^PATTERN)
module sequence_pattern_generator
  import seqgen_pkg::*;
#(
  parameter int              PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int              CNT_W   = DEF_CNT_W,
  parameter int              GAP_W   = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);
  localparam int FL = frame_len(PAT_W);
  localparam int IW = $clog2(FL);
`ifdef SEQGEN_PARITY_EN
  localparam logic [FL-1:0] FRAME = {PATTERN, ~^PATTERN};
`else
  localparam logic [FL-1:0] FRAME = PATTERN;
`endif
  state_t st, st_n;
  logic [FL-1:0] sr;
  logic [GAP_W-1:0] gap_q;
  logic ld_cfg, ld_bit, dec_bit, ld_gap, dec_gap, ld_rep, dec_rep, ld_sr, sh_sr, fin, fin_q;
  logic bit_z, gap_z, rep_z;
  seqgen_down_counter #(.W(IW)) u_bit (
    .clk(clk), .rst(rst), .load(ld_bit), .dec(dec_bit), .val(IW'(FL - 1)), .zero(bit_z)
  );
  seqgen_down_counter #(.W(GAP_W)) u_gap (
    .clk(clk), .rst(rst), .load(ld_gap), .dec(dec_gap), .val(gap_q - 1'b1), .zero(gap_z)
  );
  // holds repetitions remaining after the current frame, so zero means last frame
  seqgen_down_counter #(.W(CNT_W)) u_rep (
    .clk(clk), .rst(rst), .load(ld_rep), .dec(dec_rep),
    .val(repeat_cnt == '0 ? '0 : repeat_cnt - 1'b1), .zero(rep_z)
  );
  always_comb begin
    st_n = st;
    ld_cfg = 1'b0;
    ld_bit = 1'b0;
    dec_bit = 1'b0;
    ld_gap = 1'b0;
    dec_gap = 1'b0;
    ld_rep = 1'b0;
    dec_rep = 1'b0;
    ld_sr = 1'b0;
    sh_sr = 1'b0;
    fin = 1'b0;
    case (st)
      IDLE: if (start && !abort) begin
        st_n = SEND;
        ld_cfg = 1'b1;
        ld_bit = 1'b1;
        ld_rep = 1'b1;
        ld_sr = 1'b1;
      end
      SEND: if (abort) st_n = IDLE;
      else begin
        sh_sr = 1'b1;
        dec_bit = 1'b1;
        if (bit_z) begin
          if (rep_z) begin
            st_n = IDLE;
            fin = 1'b1;
          end else begin
            dec_rep = 1'b1;
            if (gap_q != '0) begin
              st_n = GAP;
              ld_gap = 1'b1;
            end else begin
              ld_bit = 1'b1;
              ld_sr = 1'b1;
            end
          end
        end
      end
      GAP: if (abort) st_n = IDLE;
      else if (gap_z) begin
        st_n = SEND;
        ld_bit = 1'b1;
        ld_sr = 1'b1;
      end else dec_gap = 1'b1;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      sr <= '0;
      gap_q <= '0;
      fin_q <= 1'b0;
      dout <= 1'b0;
      dvalid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st_n;
      sr <= ld_sr ? FRAME : sh_sr ? {sr[FL-2:0], 1'b0} : sr;
      gap_q <= ld_cfg ? gap_len : gap_q;
      // done trails the last bit by one cycle because outputs lag the state
      fin_q <= fin;
      done <= fin_q;
      dout <= st == SEND && !abort && sr[FL-1];
      dvalid <= st == SEND && !abort;
      busy <= st != IDLE && !abort;
    end
endmodule
